// File: rtl/main_core_pkg.sv
// main_core shared types: opcodes, ALU ops, immediate formats, decode bundle.
// Optional mul support is enabled by defining MAIN_CORE_MUL_EN.
package main_core_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MUL  = 7'b0000001;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_SLL,
    ALU_SRL,
    ALU_MUL
  } alu_op_e;

  typedef enum logic [1:0] {
    IMM_I,
    IMM_S,
    IMM_B
  } imm_fmt_e;

  typedef struct packed {
    logic     reg_we;
    logic     mem_we;
    logic     mem_to_reg;
    logic     use_imm;
    logic     branch;
    logic     br_ne;
    alu_op_e  alu_op;
    imm_fmt_e imm_fmt;
  } ctrl_t;

  function automatic logic [31:0] gen_imm(
    input logic [31:0] ins,
    input imm_fmt_e    fmt
  );
    logic [31:0] imm;
    imm = {{20{ins[31]}}, ins[31:20]};
    unique case (fmt)
      IMM_S: imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      IMM_B: imm = {{19{ins[31]}}, ins[31], ins[7],
                    ins[30:25], ins[11:8], 1'b0};
      default: ;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/main_core_alu.sv
// main_core ALU: combinational, 32-bit wrap-around arithmetic.
// The mul path exists only when MAIN_CORE_MUL_EN is defined.
module main_core_alu
  import main_core_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  alu_op_e     alu_op,
  output logic [31:0] result,
  output logic        zero
);

  always_comb begin
    result = '0;
    unique case (alu_op)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_SLL: result = a << b[4:0];
      ALU_SRL: result = a >> b[4:0];
`ifdef MAIN_CORE_MUL_EN
      ALU_MUL: result = a * b;
`endif
      default: result = '0;
    endcase
  end

  assign zero = (result == 32'd0);

endmodule

// File: rtl/main_core.sv
// main_core: single-cycle RV32I-subset core with ROM, regfile and RAM.
// Define MAIN_CORE_MUL_EN to decode R-type mul.
module main_core
  import main_core_pkg::*;
#(
  parameter string IMEM_FILE = "imem.hex",
  parameter int    MEM_WORDS = 32
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] reg0,
  output logic [31:0] reg1,
  output logic [31:0] reg2,
  output logic [31:0] reg3,
  output logic [31:0] reg4,
  output logic [31:0] reg5,
  output logic [31:0] reg6,
  output logic [31:0] reg7,
  output logic [31:0] reg8,
  output logic [31:0] reg9,
  output logic [31:0] reg10,
  output logic [31:0] reg11,
  output logic [31:0] reg12,
  output logic [31:0] reg13,
  output logic [31:0] reg14,
  output logic [31:0] reg15,
  output logic [31:0] reg16,
  output logic [31:0] reg17,
  output logic [31:0] reg18,
  output logic [31:0] reg19,
  output logic [31:0] reg20,
  output logic [31:0] reg21,
  output logic [31:0] reg22,
  output logic [31:0] reg23,
  output logic [31:0] reg24,
  output logic [31:0] reg25,
  output logic [31:0] reg26,
  output logic [31:0] reg27,
  output logic [31:0] reg28,
  output logic [31:0] reg29,
  output logic [31:0] reg30,
  output logic [31:0] reg31,
  output logic [31:0] mem0,
  output logic [31:0] mem1,
  output logic [31:0] mem2,
  output logic [31:0] mem3,
  output logic [31:0] mem4,
  output logic [31:0] mem5,
  output logic [31:0] mem6,
  output logic [31:0] mem7,
  output logic [31:0] mem8,
  output logic [31:0] mem9,
  output logic [31:0] mem10,
  output logic [31:0] mem11,
  output logic [31:0] mem12,
  output logic [31:0] mem13,
  output logic [31:0] mem14,
  output logic [31:0] mem15,
  output logic [31:0] mem16,
  output logic [31:0] mem17,
  output logic [31:0] mem18,
  output logic [31:0] mem19,
  output logic [31:0] mem20,
  output logic [31:0] mem21,
  output logic [31:0] mem22,
  output logic [31:0] mem23,
  output logic [31:0] mem24,
  output logic [31:0] mem25,
  output logic [31:0] mem26,
  output logic [31:0] mem27,
  output logic [31:0] mem28,
  output logic [31:0] mem29,
  output logic [31:0] mem30,
  output logic [31:0] mem31
);

  logic [31:0] imem [MEM_WORDS];
  logic [31:0] rf   [32];
  logic [31:0] dmem [MEM_WORDS];

  logic [6:0]  pc;
  logic [6:0]  pc_next;
  logic [31:0] instr;
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  ctrl_t       ctl;
  logic [31:0] imm;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [31:0] alu_b;
  logic [31:0] alu_res;
  logic        alu_zero;
  logic [31:0] wb_data;
  logic        taken;

  assign instr = imem[pc[6:2]];
  assign opc   = instr[6:0];
  assign rd    = instr[11:7];
  assign f3    = instr[14:12];
  assign rs1   = instr[19:15];
  assign rs2   = instr[24:20];
  assign f7    = instr[31:25];

  always_comb begin
    ctl         = '0;
    ctl.alu_op  = ALU_ADD;
    ctl.imm_fmt = IMM_I;
    unique case (1'b1)
      opc == OP_R: begin
        ctl.reg_we = 1'b1;
        case ({f7, f3})
          {F7_BASE, 3'b000}: ctl.alu_op = ALU_ADD;
          {F7_ALT,  3'b000}: ctl.alu_op = ALU_SUB;
          {F7_BASE, 3'b111}: ctl.alu_op = ALU_AND;
          {F7_BASE, 3'b110}: ctl.alu_op = ALU_OR;
          {F7_BASE, 3'b100}: ctl.alu_op = ALU_XOR;
          {F7_BASE, 3'b001}: ctl.alu_op = ALU_SLL;
          {F7_BASE, 3'b101}: ctl.alu_op = ALU_SRL;
`ifdef MAIN_CORE_MUL_EN
          {F7_MUL,  3'b000}: ctl.alu_op = ALU_MUL;
`endif
          default: ctl.reg_we = 1'b0;
        endcase
      end
      opc == OP_I: begin
        ctl.reg_we  = 1'b1;
        ctl.use_imm = 1'b1;
        case (f3)
          3'b000:  ctl.alu_op = ALU_ADD;
          3'b111:  ctl.alu_op = ALU_AND;
          3'b110:  ctl.alu_op = ALU_OR;
          default: ctl.reg_we = 1'b0;
        endcase
      end
      opc == OP_LOAD && f3 == 3'b010: begin
        ctl.reg_we     = 1'b1;
        ctl.use_imm    = 1'b1;
        ctl.mem_to_reg = 1'b1;
      end
      opc == OP_STORE && f3 == 3'b010: begin
        ctl.mem_we  = 1'b1;
        ctl.use_imm = 1'b1;
        ctl.imm_fmt = IMM_S;
      end
      opc == OP_BRANCH && f3[2:1] == 2'b00: begin
        ctl.branch  = 1'b1;
        ctl.br_ne   = f3[0];
        ctl.alu_op  = ALU_SUB;
        ctl.imm_fmt = IMM_B;
      end
      default: ;
    endcase
  end

  assign imm     = gen_imm(instr, ctl.imm_fmt);
  assign rs1_val = (rs1 == 5'd0) ? 32'd0 : rf[rs1];
  assign rs2_val = (rs2 == 5'd0) ? 32'd0 : rf[rs2];
  assign alu_b   = ctl.use_imm ? imm : rs2_val;

  main_core_alu u_alu (
    .a      (rs1_val),
    .b      (alu_b),
    .alu_op (ctl.alu_op),
    .result (alu_res),
    .zero   (alu_zero)
  );

  assign taken   = ctl.branch && (alu_zero ^ ctl.br_ne);
  assign pc_next = taken ? pc + imm[6:0] : pc + 7'd4;
  assign wb_data = ctl.mem_to_reg ? dmem[alu_res[6:2]] : alu_res;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= '0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
      for (int i = 0; i < MEM_WORDS; i++) dmem[i] <= '0;
    end else begin
      pc <= pc_next;
      if (ctl.reg_we && rd != 5'd0) rf[rd] <= wb_data;
      if (ctl.mem_we) dmem[alu_res[6:2]] <= rs2_val;
    end
  end

  assign reg0  = 32'd0;
  assign reg1  = rf[1];
  assign reg2  = rf[2];
  assign reg3  = rf[3];
  assign reg4  = rf[4];
  assign reg5  = rf[5];
  assign reg6  = rf[6];
  assign reg7  = rf[7];
  assign reg8  = rf[8];
  assign reg9  = rf[9];
  assign reg10 = rf[10];
  assign reg11 = rf[11];
  assign reg12 = rf[12];
  assign reg13 = rf[13];
  assign reg14 = rf[14];
  assign reg15 = rf[15];
  assign reg16 = rf[16];
  assign reg17 = rf[17];
  assign reg18 = rf[18];
  assign reg19 = rf[19];
  assign reg20 = rf[20];
  assign reg21 = rf[21];
  assign reg22 = rf[22];
  assign reg23 = rf[23];
  assign reg24 = rf[24];
  assign reg25 = rf[25];
  assign reg26 = rf[26];
  assign reg27 = rf[27];
  assign reg28 = rf[28];
  assign reg29 = rf[29];
  assign reg30 = rf[30];
  assign reg31 = rf[31];

  assign mem0  = dmem[0];
  assign mem1  = dmem[1];
  assign mem2  = dmem[2];
  assign mem3  = dmem[3];
  assign mem4  = dmem[4];
  assign mem5  = dmem[5];
  assign mem6  = dmem[6];
  assign mem7  = dmem[7];
  assign mem8  = dmem[8];
  assign mem9  = dmem[9];
  assign mem10 = dmem[10];
  assign mem11 = dmem[11];
  assign mem12 = dmem[12];
  assign mem13 = dmem[13];
  assign mem14 = dmem[14];
  assign mem15 = dmem[15];
  assign mem16 = dmem[16];
  assign mem17 = dmem[17];
  assign mem18 = dmem[18];
  assign mem19 = dmem[19];
  assign mem20 = dmem[20];
  assign mem21 = dmem[21];
  assign mem22 = dmem[22];
  assign mem23 = dmem[23];
  assign mem24 = dmem[24];
  assign mem25 = dmem[25];
  assign mem26 = dmem[26];
  assign mem27 = dmem[27];
  assign mem28 = dmem[28];
  assign mem29 = dmem[29];
  assign mem30 = dmem[30];
  assign mem31 = dmem[31];

endmodule

// File: tb/tb_main_core.sv
// Directed bench for main_core: small programs loaded into the ROM,
// expected architectural state queued then compared after each run.
module tb_main_core;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] rv [32];
  logic [31:0] mv [32];

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    int          kind;
    int          idx;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] prog[$];

  always #5 clk = ~clk;

  main_core #(.IMEM_FILE(""), .MEM_WORDS(32)) dut (
    .clk(clk), .rst(rst),
    .reg0(rv[0]),   .reg1(rv[1]),   .reg2(rv[2]),   .reg3(rv[3]),
    .reg4(rv[4]),   .reg5(rv[5]),   .reg6(rv[6]),   .reg7(rv[7]),
    .reg8(rv[8]),   .reg9(rv[9]),   .reg10(rv[10]), .reg11(rv[11]),
    .reg12(rv[12]), .reg13(rv[13]), .reg14(rv[14]), .reg15(rv[15]),
    .reg16(rv[16]), .reg17(rv[17]), .reg18(rv[18]), .reg19(rv[19]),
    .reg20(rv[20]), .reg21(rv[21]), .reg22(rv[22]), .reg23(rv[23]),
    .reg24(rv[24]), .reg25(rv[25]), .reg26(rv[26]), .reg27(rv[27]),
    .reg28(rv[28]), .reg29(rv[29]), .reg30(rv[30]), .reg31(rv[31]),
    .mem0(mv[0]),   .mem1(mv[1]),   .mem2(mv[2]),   .mem3(mv[3]),
    .mem4(mv[4]),   .mem5(mv[5]),   .mem6(mv[6]),   .mem7(mv[7]),
    .mem8(mv[8]),   .mem9(mv[9]),   .mem10(mv[10]), .mem11(mv[11]),
    .mem12(mv[12]), .mem13(mv[13]), .mem14(mv[14]), .mem15(mv[15]),
    .mem16(mv[16]), .mem17(mv[17]), .mem18(mv[18]), .mem19(mv[19]),
    .mem20(mv[20]), .mem21(mv[21]), .mem22(mv[22]), .mem23(mv[23]),
    .mem24(mv[24]), .mem25(mv[25]), .mem26(mv[26]), .mem27(mv[27]),
    .mem28(mv[28]), .mem29(mv[29]), .mem30(mv[30]), .mem31(mv[31])
  );

  function automatic logic [31:0] enc_r(
    input logic [6:0] f7, input int rs2, input int rs1,
    input logic [2:0] f3, input int rd
  );
    return {f7, 5'(rs2), 5'(rs1), f3, 5'(rd), 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(
    input int imm, input int rs1, input logic [2:0] f3,
    input int rd, input logic [6:0] op
  );
    logic [31:0] v;
    v = imm;
    return {v[11:0], 5'(rs1), f3, 5'(rd), op};
  endfunction

  function automatic logic [31:0] enc_s(
    input int imm, input int rs2, input int rs1
  );
    logic [31:0] v;
    v = imm;
    return {v[11:5], 5'(rs2), 5'(rs1), 3'b010, v[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(
    input int imm, input int rs2, input int rs1, input logic [2:0] f3
  );
    logic [31:0] v;
    v = imm;
    return {v[12], v[10:5], 5'(rs2), 5'(rs1), f3,
            v[4:1], v[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
    return enc_i(imm, rs1, 3'b000, rd, 7'b0010011);
  endfunction

  function automatic logic [31:0] halt();
    return enc_b(0, 0, 0, 3'b000);
  endfunction

  task automatic push(input string tag, input int kind, input int idx, input logic [31:0] val);
    exp_t e;
    e.tag  = tag;
    e.kind = kind;
    e.idx  = idx;
    e.val  = val;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t        e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.kind)
        0:       obs = rv[e.idx];
        1:       obs = mv[e.idx];
        default: obs = {25'd0, dut.pc};
      endcase
      checks++;
      assert (obs === e.val) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic load_prog();
    for (int i = 0; i < 32; i++)
      dut.imem[i] = (i < prog.size()) ? prog[i] : 32'd0;
    prog.delete();
  endtask

  task automatic run(input int cycles);
    rst = 1'b1;
    load_prog();
    @(negedge clk);
    rst = 1'b0;
    repeat (cycles) @(negedge clk);
  endtask

  initial begin
    // reset state seen after a clock edge with rst high
    prog.push_back(halt());
    load_prog();
    @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      push($sformatf("rst_reg%0d", i), 0, i, 32'd0);
      push($sformatf("rst_mem%0d", i), 1, i, 32'd0);
    end
    push("rst_pc", 2, 0, 32'd0);
    drain();

    // arithmetic
    prog.push_back(addi(1, 0, 5));
    prog.push_back(addi(2, 0, -3));
    prog.push_back(enc_r(7'h00, 2, 1, 3'b000, 3));
    prog.push_back(enc_r(7'h20, 2, 1, 3'b000, 4));
    prog.push_back(halt());
    push("arith_x1", 0, 1, 32'd5);
    push("arith_x2", 0, 2, 32'hFFFF_FFFD);
    push("arith_add", 0, 3, 32'd2);
    push("arith_sub", 0, 4, 32'd8);
    push("arith_pc", 2, 0, 32'd16);
    run(10);
    drain();

    // logic and shifts, x0 write, unknown opcode
    prog.push_back(addi(1, 0, 32'hF0));
    prog.push_back(addi(2, 0, 4));
    prog.push_back(enc_r(7'h00, 2, 1, 3'b111, 5));
    prog.push_back(enc_r(7'h00, 2, 1, 3'b110, 6));
    prog.push_back(enc_r(7'h00, 2, 1, 3'b100, 7));
    prog.push_back(enc_r(7'h00, 2, 1, 3'b001, 8));
    prog.push_back(enc_r(7'h00, 2, 1, 3'b101, 9));
    prog.push_back(addi(0, 0, 7));
    prog.push_back(32'hFFFF_FFFF);
    prog.push_back(halt());
    push("logic_and", 0, 5, 32'd0);
    push("logic_or", 0, 6, 32'hF4);
    push("logic_xor", 0, 7, 32'hF4);
    push("logic_sll", 0, 8, 32'hF00);
    push("logic_srl", 0, 9, 32'hF);
    push("logic_x0", 0, 0, 32'd0);
    push("logic_x10", 0, 10, 32'd0);
    push("logic_pc", 2, 0, 32'd36);
    run(16);
    drain();

    // memory, including address wrap past 128 bytes
    prog.push_back(addi(1, 0, 42));
    prog.push_back(enc_s(8, 1, 0));
    prog.push_back(enc_i(8, 0, 3'b010, 2, 7'b0000011));
    prog.push_back(enc_s(132, 1, 0));
    prog.push_back(halt());
    push("mem_w2", 1, 2, 32'd42);
    push("mem_lw", 0, 2, 32'd42);
    push("mem_wrap", 1, 1, 32'd42);
    push("mem_w0", 1, 0, 32'd0);
    run(10);
    drain();

    // async reset mid-run, away from any clock edge
    #2;
    rst = 1'b1;
    #1;
    push("arst_reg1", 0, 1, 32'd0);
    push("arst_reg2", 0, 2, 32'd0);
    push("arst_mem1", 1, 1, 32'd0);
    push("arst_mem2", 1, 2, 32'd0);
    push("arst_pc", 2, 0, 32'd0);
    drain();
    repeat (3) @(negedge clk);
    push("hold_pc", 2, 0, 32'd0);
    push("hold_reg1", 0, 1, 32'd0);
    drain();

    // branch loop to a self-branch halt
    prog.push_back(addi(1, 0, 3));
    prog.push_back(addi(1, 1, -1));
    prog.push_back(enc_b(-4, 0, 1, 3'b001));
    prog.push_back(halt());
    push("br_x1", 0, 1, 32'd0);
    push("br_pc", 2, 0, 32'd12);
    run(20);
    drain();
    repeat (5) @(negedge clk);
    push("br_pc_stable", 2, 0, 32'd12);
    push("br_x1_stable", 0, 1, 32'd0);
    drain();

    // optional multiply
    prog.push_back(addi(1, 0, 6));
    prog.push_back(addi(2, 0, 7));
    prog.push_back(enc_r(7'h01, 2, 1, 3'b000, 3));
    prog.push_back(halt());
`ifdef MAIN_CORE_MUL_EN
    push("mul_x3", 0, 3, 32'd42);
`else
    push("mul_x3", 0, 3, 32'd0);
`endif
    push("mul_x2", 0, 2, 32'd7);
    run(8);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
